bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares a single binary-to-BCD converter (32-bit in, 8-digit BCD out, trigger/idle handshake, roughly 64 clocks per conversion) between NUM_REQ requesters, e.g. time display, alarm display and set-mode display. Each requester issues a request, the arbiter grants requesters round-robin, drives the converter, and returns the BCD word with a one-cycle done pulse. It sits between the clock/alarm counters and the display mux.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 96, watchdog limit in clocks per conversion (used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  level request per requester; held until its done pulse
value  input  NUM_REQ*32  packed binary operands; slice i = value[32*i+31:32*i]; stable while req[i] is high
grant  output  NUM_REQ  one-hot; the requester currently being served
done  output  NUM_REQ  one-cycle pulse to the served requester; bcd_out valid in that cycle
bcd_out  output  32  last conversion result; holds until the next done
err  output  1  one-cycle pulse with done when the watchdog fired
busy  output  1  high in every state except ARB
conv_trigger  output  1  registered; start pulse to the converter
conv_in  output  32  registered operand to the converter
conv_idle  input  1  converter idle flag
conv_bcd  input  32  converter result

Behaviour:
- Reset (async, rst_n=0) sets: state=ARB, grant=0, done=0, err=0, bcd_out=0, conv_trigger=0, conv_in=0, rr_ptr=0, busy=0.
- The converter has no reset. The arbiter never issues a trigger unless conv_idle=1.
- States:
  - ARB: if |req and conv_idle, pick the first set req[i] scanning from rr_ptr upward with wrap. Register grant=onehot(i) and conv_in=value slice i, then go to ISSUE. Otherwise stay.
  - ISSUE: conv_trigger=1 for exactly this cycle, then go to WAIT_START.
  - WAIT_START: wait for conv_idle=0, then go to WAIT_DONE. conv_idle stays 1 during the trigger cycle, so a done must never be taken from ISSUE.
  - WAIT_DONE: on conv_idle=1, register bcd_out=conv_bcd and done=grant, then go to RESP.
  - RESP: done is high for this cycle only. Clear grant, set rr_ptr=(i+1) mod NUM_REQ, go to ARB.
- Requesters drop req in the cycle after done. ARB evaluates only after RESP, so no double service occurs.
- If req[i] drops mid-service, the conversion completes. bcd_out is not updated, done stays 0, and rr_ptr still advances.
- If all requesters assert simultaneously, each is served exactly once in round-robin order before any is served twice.
- Latency from ARB seeing req to done high: 4 cycles plus the converter busy time.
- Reset mid-conversion returns the arbiter to ARB. It waits for conv_idle=1 (the converter finishing its stale job) before granting; the stale result is never reported.
- With NUM_REQ=1 the arbiter degenerates to a sequencer; rr_ptr stays 0.

Optional Feature:
BCD_ARB_TIMEOUT_EN
- Defined: a counter clears on entering WAIT_START and counts in WAIT_START and WAIT_DONE. On reaching TIMEOUT_CYCLES, go to RESP with done=grant, err=1 and bcd_out=32'hFFFF_FFFF. ARB continues to gate new grants on conv_idle.
- Undefined: no counter; err is tied 0; WAIT_START and WAIT_DONE wait indefinitely.

Test Plan:
- Single request: req=3'b001, value0=12345 -> conv_trigger exactly one pulse; done=3'b001 once; bcd_out=32'h0001_2345; grant=0 after RESP.
- Simultaneous requests: req=3'b111, values 59, 23, 0 -> done order 001, 010, 100; bcd_out 32'h59, 32'h23, 32'h0; exactly three triggers.
- Fairness: req0 held and re-asserted continuously, req1 asserted once -> req1 served immediately after the first req0 service, not starved.
- Request withdrawn: req1 drops during WAIT_DONE -> done stays 0, bcd_out keeps its previous value, next grant goes to req2.
- Reset mid-conversion: rst_n low for 2 cycles during WAIT_DONE with req0 still high -> outputs at reset values; no trigger until conv_idle=1; then a normal conversion with correct BCD.
- Timeout (macro on, TIMEOUT_CYCLES=96, conv_idle forced low) -> done and err pulse together after 96 cycles; bcd_out=32'hFFFF_FFFF.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// ============================================================================
// Module   : bcd_conv_arbiter
// Brief    : Round-robin sharing of one binary-to-BCD converter among
//            NUM_REQ requesters. Optional watchdog: BCD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   value,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             bcd_out,
  output logic                    err,
  output logic                    busy,
  output logic                    conv_trigger,
  output logic [31:0]             conv_in,
  input  logic                    conv_idle,
  input  logic [31:0]             conv_bcd
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_VAL_W = $clog2(NUM_REQ * 32);

  localparam logic [2:0] c_ST_ARB        = 3'd0;
  localparam logic [2:0] c_ST_ISSUE      = 3'd1;
  localparam logic [2:0] c_ST_WAIT_START = 3'd2;
  localparam logic [2:0] c_ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] c_ST_RESP       = 3'd4;

  logic [2:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [31:0]        r_bcd;
  logic               r_trig;
  logic [31:0]        r_conv_in;
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] r_idx;

  logic               w_pick_valid;
  logic [c_PTR_W-1:0] w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [c_VAL_W-1:0] w_val_base;
  logic               w_in_wait;
  logic               w_timeout;

  function automatic logic [c_PTR_W-1:0] wrap_idx(input logic [c_PTR_W-1:0] base,
                                                  input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[c_PTR_W-1:0];
  endfunction

  // Scan downward in distance so the requester closest to rr_ptr wins.
  always_comb begin
    w_pick_valid  = 1'b0;
    w_pick_idx    = '0;
    w_pick_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(r_rr_ptr, k)]) begin
        w_pick_valid                          = 1'b1;
        w_pick_idx                            = wrap_idx(r_rr_ptr, k);
        w_pick_onehot                         = '0;
        w_pick_onehot[wrap_idx(r_rr_ptr, k)]  = 1'b1;
      end
    end
  end

  assign w_val_base = c_VAL_W'(int'(w_pick_idx) * 32);
  assign w_in_wait  = (r_state == c_ST_WAIT_START) || (r_state == c_ST_WAIT_DONE);

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  assign w_timeout = w_in_wait && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == c_ST_ISSUE) begin
        r_cnt <= '0;
      end else if (w_in_wait) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_ARB;
      r_grant   <= '0;
      r_done    <= '0;
      r_bcd     <= '0;
      r_trig    <= 1'b0;
      r_conv_in <= '0;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
    end else begin
      r_trig <= 1'b0;
      r_done <= '0;
      case (r_state)
        c_ST_ARB: begin
          // conv_idle gating also covers a stale job left over from reset.
          if (w_pick_valid && conv_idle) begin
            r_grant   <= w_pick_onehot;
            r_idx     <= w_pick_idx;
            r_conv_in <= value[w_val_base +: 32];
            r_trig    <= 1'b1;
            r_state   <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_state <= c_ST_WAIT_START;
        end
        c_ST_WAIT_START: begin
          if (w_timeout) begin
            r_done  <= r_grant;
            r_bcd   <= 32'hFFFF_FFFF;
            r_state <= c_ST_RESP;
          end else if (!conv_idle) begin
            r_state <= c_ST_WAIT_DONE;
          end
        end
        c_ST_WAIT_DONE: begin
          if (conv_idle) begin
            // A withdrawn requester gets no pulse and leaves bcd_out untouched.
            r_done <= r_grant & req;
            if (|(r_grant & req)) r_bcd <= conv_bcd;
            r_state <= c_ST_RESP;
          end else if (w_timeout) begin
            r_done  <= r_grant;
            r_bcd   <= 32'hFFFF_FFFF;
            r_state <= c_ST_RESP;
          end
        end
        c_ST_RESP: begin
          r_grant  <= '0;
          r_rr_ptr <= wrap_idx(r_idx, 1);
          r_state  <= c_ST_ARB;
        end
        default: begin
          r_state <= c_ST_ARB;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign bcd_out      = r_bcd;
  assign busy         = (r_state != c_ST_ARB);
  assign conv_trigger = r_trig;
  assign conv_in      = r_conv_in;

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
// ============================================================================
// Module   : tb_bcd_conv_arbiter
// Brief    : Directed bench for bcd_conv_arbiter with a behavioural converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int CONV_LAT = 12;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] value;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           bcd_out;
  logic                  err;
  logic                  busy;
  logic                  conv_trigger;
  logic [31:0]           conv_in;
  logic                  conv_idle;
  logic [31:0]           conv_bcd;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int t0;
  logic [NUM_REQ-1:0] hold_mask;
  logic               force_low;
  logic [NUM_REQ-1:0] done_log[$];
  logic [31:0]        bcd_log[$];
  logic               err_log[$];

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(96)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .value(value), .grant(grant),
    .done(done), .bcd_out(bcd_out), .err(err), .busy(busy),
    .conv_trigger(conv_trigger), .conv_in(conv_in),
    .conv_idle(conv_idle), .conv_bcd(conv_bcd)
  );

  // Behavioural converter: no reset, result appears when it goes idle.
  logic [7:0]  m_cnt = '0;
  logic [31:0] m_op  = '0;
  logic [31:0] m_res = '0;

  function automatic logic [31:0] bin2bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (conv_trigger && conv_idle) begin
      m_cnt <= 8'(CONV_LAT);
      m_op  <= conv_in;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 8'd1;
      if (m_cnt == 8'd1) m_res <= bin2bcd(m_op);
    end
  end

  assign conv_idle = (m_cnt == 8'd0) && !force_low;
  assign conv_bcd  = m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, log done pulses, requesters drop after done.
  task automatic tick();
    req = req | hold_mask;
    @(negedge clk);
    if (conv_trigger) begin
      trig_cnt++;
      check("trigger_while_idle", 32'(conv_idle), 32'd1);
    end
    if (|done) begin
      done_log.push_back(done);
      bcd_log.push_back(bcd_out);
      err_log.push_back(err);
      req = req & ~done;
    end
  endtask

  task automatic wait_done(input int n, input int bound);
    int c;
    c = 0;
    while (done_log.size() < n && c < bound) begin
      tick();
      c++;
    end
    check("done_count", 32'(done_log.size()), 32'(n));
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] g, input int bound);
    int c;
    c = 0;
    while (grant !== g && c < bound) begin
      tick();
      c++;
    end
    check("grant_seen", 32'(grant), 32'(g));
  endtask

  task automatic wait_idle(input logic v, input int bound);
    int c;
    c = 0;
    while (conv_idle !== v && c < bound) begin
      tick();
      c++;
    end
    check("conv_idle_seen", 32'(conv_idle), 32'(v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd_out"}, bcd_out, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_trigger"}, 32'(conv_trigger), 32'd0);
    check({tag, "_conv_in"}, conv_in, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    value     = '0;
    hold_mask = '0;
    force_low = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All three at once: served 0,1,2.
    value = {32'd0, 32'd23, 32'd59};
    req   = 3'b111;
    t0    = trig_cnt;
    wait_done(3, 600);
    check("sim_done0", 32'(done_log[0]), 32'h1);
    check("sim_done1", 32'(done_log[1]), 32'h2);
    check("sim_done2", 32'(done_log[2]), 32'h4);
    check("sim_bcd0", bcd_log[0], 32'h59);
    check("sim_bcd1", bcd_log[1], 32'h23);
    check("sim_bcd2", bcd_log[2], 32'h0);
    check("sim_err", 32'({err_log[0], err_log[1], err_log[2]}), 32'd0);
    check("sim_triggers", 32'(trig_cnt - t0), 32'd3);
    repeat (3) tick();
    check("sim_grant_idle", 32'(grant), 32'd0);
    check("sim_busy_idle", 32'(busy), 32'd0);

    // Single request.
    value[31:0] = 32'd12345;
    req         = 3'b001;
    t0          = trig_cnt;
    wait_done(4, 200);
    check("single_done", 32'(done_log[3]), 32'h1);
    check("single_bcd", bcd_log[3], 32'h0001_2345);
    check("single_triggers", 32'(trig_cnt - t0), 32'd1);
    repeat (3) tick();
    check("single_grant_after", 32'(grant), 32'd0);
    check("single_no_extra_done", 32'(done_log.size()), 32'd4);

    // Fairness: req0 held continuously, req1 arrives during req0's service.
    value[31:0]  = 32'd42;
    value[63:32] = 32'd7;
    hold_mask    = 3'b001;
    req          = 3'b001;
    wait_grant(3'b001, 20);
    req = req | 3'b010;
    wait_done(7, 400);
    hold_mask = '0;
    check("fair_done0", 32'(done_log[4]), 32'h1);
    check("fair_done1", 32'(done_log[5]), 32'h2);
    check("fair_done2", 32'(done_log[6]), 32'h1);
    check("fair_bcd1", bcd_log[5], 32'h07);
    check("fair_bcd2", bcd_log[6], 32'h42);

    // Withdrawal: req1 drops during WAIT_DONE, req2 must follow.
    value[63:32] = 32'd77;
    value[95:64] = 32'd88;
    req          = 3'b110;
    wait_grant(3'b010, 20);
    wait_idle(1'b0, 20);
    repeat (2) tick();
    req[1] = 1'b0;
    wait_grant(3'b100, 100);
    check("wd_no_done", 32'(done_log.size()), 32'd7);
    check("wd_bcd_held", bcd_out, 32'h42);
    wait_done(8, 200);
    check("wd_done2", 32'(done_log[7]), 32'h4);
    check("wd_bcd2", bcd_log[7], 32'h88);

    // Reset in WAIT_DONE with req0 still asserted.
    value[31:0] = 32'd99999999;
    req         = 3'b001;
    wait_grant(3'b001, 20);
    wait_idle(1'b0, 20);
    repeat (3) tick();
    t0    = trig_cnt;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    wait_idle(1'b1, 100);
    check("midrst_no_early_trigger", 32'(trig_cnt - t0), 32'd0);
    wait_done(9, 200);
    check("midrst_done", 32'(done_log[8]), 32'h1);
    check("midrst_bcd", bcd_log[8], 32'h9999_9999);
    check("midrst_triggers", 32'(trig_cnt - t0), 32'd1);

`ifdef BCD_ARB_TIMEOUT_EN
    // Watchdog: converter never leaves busy after the trigger.
    value[31:0] = 32'd5;
    req         = 3'b001;
    t0          = trig_cnt;
    begin
      int c;
      c = 0;
      while (trig_cnt == t0 && c < 50) begin
        tick();
        c++;
      end
    end
    check("to_triggered", 32'(trig_cnt - t0), 32'd1);
    force_low = 1'b1;
    wait_done(10, 300);
    check("to_done", 32'(done_log[9]), 32'h1);
    check("to_err", 32'(err_log[9]), 32'd1);
    check("to_bcd", bcd_log[9], 32'hFFFF_FFFF);
    force_low = 1'b0;
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
